// File: rtl/ysyx_23060025_wbu.sv
// Write-back stage: latches the LSU bundle, commits GPR/CSR updates in one COMMIT cycle,
// and owns the machine-mode CSR file plus the mcycle/minstret counters.
module ysyx_23060025_wbu #(
  parameter int                DATA_LEN  = 32,
  parameter int                ADDR_LEN  = 32,
  parameter logic [DATA_LEN-1:0] MTVEC_RST = 32'h0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                lsu_valid_i,
  output logic                wb_ready_o,
  input  logic                wd_i,
  input  logic [4:0]          wreg_i,
  input  logic [DATA_LEN-1:0] wdata_i,
  input  logic [2:0]          csr_type_i,
  input  logic [11:0]         csr_addr_i,
  input  logic [DATA_LEN-1:0] csr_wdata_i,
  input  logic [ADDR_LEN-1:0] pc_i,
  output logic                reg_wen_o,
  output logic [4:0]          reg_waddr_o,
  output logic [DATA_LEN-1:0] reg_wdata_o,
  input  logic [11:0]         csr_raddr_i,
  output logic [DATA_LEN-1:0] csr_rdata_o,
  output logic                wb_valid_o,
  output logic                redirect_o,
  output logic [ADDR_LEN-1:0] redirect_pc_o
);

  typedef enum logic {WB_IDLE, WB_COMMIT} wb_state_t;

  localparam logic [2:0] CSR_WRITE = 3'b001;
  localparam logic [2:0] CSR_ECALL = 3'b010;
  localparam logic [2:0] CSR_MRET  = 3'b011;

  wb_state_t state, state_next;

  logic                wd_p0;
  logic [4:0]          wreg_p0;
  logic [DATA_LEN-1:0] wdata_p0;
  logic [2:0]          csr_type_p0;
  logic [11:0]         csr_addr_p0;
  logic [DATA_LEN-1:0] csr_wdata_p0;
  logic [ADDR_LEN-1:0] pc_p0;

  logic [DATA_LEN-1:0] mstatus, mtvec, mepc, mcause;
  logic [63:0]         mcycle, minstret;

  logic commit, capture, is_ecall, is_mret;

  always_ff @(posedge clock) begin
    if (reset) state <= WB_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      WB_IDLE:   if (lsu_valid_i) state_next = WB_COMMIT;
      WB_COMMIT: state_next = WB_IDLE;
      default:   state_next = WB_IDLE;
    endcase
  end

  assign capture  = !reset && (state == WB_IDLE) && lsu_valid_i;
  assign commit   = !reset && (state == WB_COMMIT);
  assign is_ecall = csr_type_p0 == CSR_ECALL;
  assign is_mret  = csr_type_p0 == CSR_MRET;

  // ---- stage p0: bundle capture (data only, no reset) ----
  always_ff @(posedge clock) begin
    if (capture) begin
      wd_p0        <= wd_i;
      wreg_p0      <= wreg_i;
      wdata_p0     <= wdata_i;
      csr_type_p0  <= csr_type_i;
      csr_addr_p0  <= csr_addr_i;
      csr_wdata_p0 <= csr_wdata_i;
      pc_p0        <= pc_i;
    end
  end

  // ---- commit: CSR file and counters update at the end of COMMIT ----
  always_ff @(posedge clock) begin
    if (reset) begin
      mstatus  <= DATA_LEN'(32'h1800);
      mtvec    <= MTVEC_RST;
      mepc     <= '0;
      mcause   <= '0;
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      mcycle   <= mcycle + 64'd1;
      minstret <= minstret + {63'd0, commit};
      if (commit) begin
        if (csr_type_p0 == CSR_WRITE) begin
          case (csr_addr_p0)
            12'h300: mstatus <= csr_wdata_p0;
            12'h305: mtvec   <= csr_wdata_p0;
            12'h341: mepc    <= csr_wdata_p0;
            12'h342: mcause  <= csr_wdata_p0;
            default: ;
          endcase
        end else if (is_ecall) begin
          mepc   <= DATA_LEN'(pc_p0);
          mcause <= DATA_LEN'(11);
        end
      end
    end
  end

  always_comb begin
    csr_rdata_o = '0;
    case (csr_raddr_i)
      12'h300: csr_rdata_o = mstatus;
      12'h305: csr_rdata_o = mtvec;
      12'h341: csr_rdata_o = mepc;
      12'h342: csr_rdata_o = mcause;
      12'hB00: csr_rdata_o = DATA_LEN'(mcycle[31:0]);
      12'hB80: csr_rdata_o = DATA_LEN'(mcycle[63:32]);
      12'hB02: csr_rdata_o = DATA_LEN'(minstret[31:0]);
      12'hB82: csr_rdata_o = DATA_LEN'(minstret[63:32]);
      12'hF11: csr_rdata_o = DATA_LEN'(32'h79737978);
      12'hF12: csr_rdata_o = DATA_LEN'(32'h015FDE39);
      default: csr_rdata_o = '0;
    endcase
  end

  assign wb_ready_o  = !reset && (state == WB_IDLE);
  assign wb_valid_o  = commit;
  assign reg_wen_o   = commit && wd_p0 && (wreg_p0 != 5'd0);
  assign reg_waddr_o = wreg_p0;
  assign reg_wdata_o = wdata_p0;
  assign redirect_o  = commit && (is_ecall || is_mret);

  always_comb begin
    redirect_pc_o = '0;
    if (commit && is_ecall)     redirect_pc_o = ADDR_LEN'(mtvec);
    else if (commit && is_mret) redirect_pc_o = ADDR_LEN'(mepc);
  end

`ifndef SYNTHESIS
  // A new bundle while committing would be silently dropped.
  always @(posedge clock) begin
    if (!reset && state == WB_COMMIT) assert (!lsu_valid_i);
  end
`endif

endmodule

// File: tb/tb_ysyx_23060025_wbu.sv
// Directed bench for the write-back stage: GPR commit, CSR file, traps, counters and reset.
module tb_ysyx_23060025_wbu;
  logic        clock = 0;
  logic        reset = 1;
  logic        lsu_valid_i = 0;
  logic        wb_ready_o;
  logic        wd_i = 0;
  logic [4:0]  wreg_i = 0;
  logic [31:0] wdata_i = 0;
  logic [2:0]  csr_type_i = 0;
  logic [11:0] csr_addr_i = 0;
  logic [31:0] csr_wdata_i = 0;
  logic [31:0] pc_i = 0;
  logic        reg_wen_o;
  logic [4:0]  reg_waddr_o;
  logic [31:0] reg_wdata_o;
  logic [11:0] csr_raddr_i = 0;
  logic [31:0] csr_rdata_o;
  logic        wb_valid_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;

  int errors = 0;
  int checks = 0;
  int ninstr = 0;

  ysyx_23060025_wbu #(.DATA_LEN(32), .ADDR_LEN(32), .MTVEC_RST(32'h0)) dut (
    .clock(clock), .reset(reset), .lsu_valid_i(lsu_valid_i), .wb_ready_o(wb_ready_o),
    .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i), .csr_type_i(csr_type_i),
    .csr_addr_i(csr_addr_i), .csr_wdata_i(csr_wdata_i), .pc_i(pc_i),
    .reg_wen_o(reg_wen_o), .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o),
    .csr_raddr_i(csr_raddr_i), .csr_rdata_o(csr_rdata_o), .wb_valid_o(wb_valid_o),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o)
  );

  always #5 clock = ~clock;

  // Drives one LSU bundle just after a falling edge; returns 1 time unit into the COMMIT cycle.
  task automatic issue(input logic wd, input logic [4:0] wreg, input logic [31:0] wdata,
                       input logic [2:0] ctype, input logic [11:0] caddr,
                       input logic [31:0] cwdata, input logic [31:0] pc);
    wd_i = wd; wreg_i = wreg; wdata_i = wdata; csr_type_i = ctype;
    csr_addr_i = caddr; csr_wdata_i = cwdata; pc_i = pc;
    lsu_valid_i = 1;
    @(negedge clock);
    lsu_valid_i = 0;
    wd_i = 0; wreg_i = 0; wdata_i = 0; csr_type_i = 0; csr_addr_i = 0; csr_wdata_i = 0; pc_i = 0;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clock); #1;
    checks++; if ({wb_ready_o, wb_valid_o, reg_wen_o, redirect_o} !== 4'b0000) begin errors++;
      $display("FAIL rst_ctrl got=%b exp=0000", {wb_ready_o, wb_valid_o, reg_wen_o, redirect_o}); end
    checks++; if (redirect_pc_o !== 32'h0) begin errors++;
      $display("FAIL rst_redirect_pc got=%h exp=00000000", redirect_pc_o); end
    @(negedge clock);
    reset = 0; ninstr = 0;
    csr_raddr_i = 12'hB00; #1;
    checks++; if (csr_rdata_o !== 32'h0) begin errors++; $display("FAIL mcycle_start got=%h exp=0", csr_rdata_o); end
    checks++; if (wb_ready_o !== 1'b1) begin errors++; $display("FAIL idle_ready got=%b exp=1", wb_ready_o); end
    @(negedge clock); #1;
    checks++; if (csr_rdata_o !== 32'h1) begin errors++; $display("FAIL mcycle_inc got=%h exp=1", csr_rdata_o); end
    csr_raddr_i = 12'h300; #1;
    checks++; if (csr_rdata_o !== 32'h1800) begin errors++; $display("FAIL mstatus_rst got=%h exp=1800", csr_rdata_o); end
    csr_raddr_i = 12'h305; #1;
    checks++; if (csr_rdata_o !== 32'h0) begin errors++; $display("FAIL mtvec_rst got=%h exp=0", csr_rdata_o); end
    csr_raddr_i = 12'hF11; #1;
    checks++; if (csr_rdata_o !== 32'h79737978) begin errors++; $display("FAIL mvendorid got=%h exp=79737978", csr_rdata_o); end
    csr_raddr_i = 12'hF12; #1;
    checks++; if (csr_rdata_o !== 32'h015FDE39) begin errors++; $display("FAIL marchid got=%h exp=015fde39", csr_rdata_o); end
    csr_raddr_i = 12'h123; #1;
    checks++; if (csr_rdata_o !== 32'h0) begin errors++; $display("FAIL unimpl_csr got=%h exp=0", csr_rdata_o); end
  endtask

  task automatic test_alu_writeback();
    @(negedge clock);
    issue(1'b1, 5'd5, 32'hDEADBEEF, 3'b000, 12'h0, 32'h0, 32'h80000000); ninstr++;
    checks++; if ({reg_wen_o, wb_valid_o, redirect_o, wb_ready_o} !== 4'b1100) begin errors++;
      $display("FAIL alu_ctrl got=%b exp=1100", {reg_wen_o, wb_valid_o, redirect_o, wb_ready_o}); end
    checks++; if (reg_waddr_o !== 5'd5 || reg_wdata_o !== 32'hDEADBEEF) begin errors++;
      $display("FAIL alu_data got=%0d/%h exp=5/deadbeef", reg_waddr_o, reg_wdata_o); end
    checks++; if (redirect_pc_o !== 32'h0) begin errors++; $display("FAIL alu_redirect_pc got=%h exp=0", redirect_pc_o); end
    @(negedge clock); csr_raddr_i = 12'hB02; #1;
    checks++; if ({reg_wen_o, wb_valid_o, wb_ready_o} !== 3'b001) begin errors++;
      $display("FAIL alu_pulse_end got=%b exp=001", {reg_wen_o, wb_valid_o, wb_ready_o}); end
    checks++; if (csr_rdata_o !== ninstr) begin errors++; $display("FAIL alu_minstret got=%0d exp=%0d", csr_rdata_o, ninstr); end
  endtask

  task automatic test_x0_write();
    @(negedge clock);
    issue(1'b1, 5'd0, 32'h1234, 3'b000, 12'h0, 32'h0, 32'h80000004); ninstr++;
    checks++; if ({reg_wen_o, wb_valid_o} !== 2'b01) begin errors++;
      $display("FAIL x0_ctrl got=%b exp=01", {reg_wen_o, wb_valid_o}); end
    @(negedge clock); csr_raddr_i = 12'hB02; #1;
    checks++; if (csr_rdata_o !== ninstr) begin errors++; $display("FAIL x0_minstret got=%0d exp=%0d", csr_rdata_o, ninstr); end
  endtask

  task automatic test_csr_write();
    @(negedge clock);
    issue(1'b0, 5'd0, 32'h0, 3'b001, 12'h305, 32'h80000100, 32'h80000008); ninstr++;
    csr_raddr_i = 12'h305; #1;
    checks++; if (csr_rdata_o !== 32'h0) begin errors++; $display("FAIL csr_no_bypass got=%h exp=0", csr_rdata_o); end
    checks++; if (reg_wen_o !== 1'b0) begin errors++; $display("FAIL csr_wen got=%b exp=0", reg_wen_o); end
    @(negedge clock); #1;
    checks++; if (csr_rdata_o !== 32'h80000100) begin errors++; $display("FAIL mtvec_write got=%h exp=80000100", csr_rdata_o); end
    issue(1'b0, 5'd0, 32'h0, 3'b001, 12'hF11, 32'h12345678, 32'h8000000C); ninstr++;
    @(negedge clock); csr_raddr_i = 12'hF11; #1;
    checks++; if (csr_rdata_o !== 32'h79737978) begin errors++; $display("FAIL ro_write got=%h exp=79737978", csr_rdata_o); end
  endtask

  task automatic test_ecall_mret();
    @(negedge clock);
    issue(1'b0, 5'd0, 32'h0, 3'b010, 12'h0, 32'h0, 32'h80000040); ninstr++;
    checks++; if ({redirect_o, wb_valid_o} !== 2'b11) begin errors++;
      $display("FAIL ecall_ctrl got=%b exp=11", {redirect_o, wb_valid_o}); end
    checks++; if (redirect_pc_o !== 32'h80000100) begin errors++; $display("FAIL ecall_pc got=%h exp=80000100", redirect_pc_o); end
    @(negedge clock); csr_raddr_i = 12'h341; #1;
    checks++; if (csr_rdata_o !== 32'h80000040) begin errors++; $display("FAIL ecall_mepc got=%h exp=80000040", csr_rdata_o); end
    csr_raddr_i = 12'h342; #1;
    checks++; if (csr_rdata_o !== 32'd11) begin errors++; $display("FAIL ecall_mcause got=%h exp=b", csr_rdata_o); end
    issue(1'b0, 5'd0, 32'h0, 3'b011, 12'h0, 32'h0, 32'h80000100); ninstr++;
    checks++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h80000040) begin errors++;
      $display("FAIL mret_pc got=%b/%h exp=1/80000040", redirect_o, redirect_pc_o); end
    @(negedge clock); csr_raddr_i = 12'h300; #1;
    checks++; if (csr_rdata_o !== 32'h1800) begin errors++; $display("FAIL mret_mstatus got=%h exp=1800", csr_rdata_o); end
  endtask

  task automatic test_back_to_back();
    @(negedge clock);
    issue(1'b1, 5'd10, 32'hA5A5A5A5, 3'b000, 12'h0, 32'h0, 32'h80000010); ninstr++;
    checks++; if (reg_wen_o !== 1'b1 || reg_waddr_o !== 5'd10 || reg_wdata_o !== 32'hA5A5A5A5) begin errors++;
      $display("FAIL b2b_first got=%b/%0d/%h exp=1/10/a5a5a5a5", reg_wen_o, reg_waddr_o, reg_wdata_o); end
    @(negedge clock);
    issue(1'b1, 5'd31, 32'h0000FFFF, 3'b111, 12'h305, 32'h1, 32'h80000014); ninstr++;
    checks++; if (reg_wen_o !== 1'b1 || reg_waddr_o !== 5'd31 || reg_wdata_o !== 32'h0000FFFF || redirect_o !== 1'b0) begin errors++;
      $display("FAIL b2b_second got=%b/%0d/%h/%b exp=1/31/0000ffff/0", reg_wen_o, reg_waddr_o, reg_wdata_o, redirect_o); end
    @(negedge clock); csr_raddr_i = 12'h305; #1;
    checks++; if (csr_rdata_o !== 32'h80000100) begin errors++; $display("FAIL type7_ignored got=%h exp=80000100", csr_rdata_o); end
    csr_raddr_i = 12'hB02; #1;
    checks++; if (csr_rdata_o !== ninstr) begin errors++; $display("FAIL b2b_minstret got=%0d exp=%0d", csr_rdata_o, ninstr); end
  endtask

  task automatic test_counter_wrap();
    @(negedge clock);
    force dut.mcycle = 64'h00000000_FFFFFFFF; #1; release dut.mcycle;
    @(negedge clock); csr_raddr_i = 12'hB80; #1;
    checks++; if (csr_rdata_o !== 32'h1) begin errors++; $display("FAIL mcycleh_carry got=%h exp=1", csr_rdata_o); end
    csr_raddr_i = 12'hB00; #1;
    checks++; if (csr_rdata_o !== 32'h0) begin errors++; $display("FAIL mcycle_wrap got=%h exp=0", csr_rdata_o); end
    @(negedge clock);
    force dut.minstret = 64'h00000000_FFFFFFFF; #1; release dut.minstret;
    issue(1'b0, 5'd0, 32'h0, 3'b000, 12'h0, 32'h0, 32'h80000018);
    @(negedge clock); csr_raddr_i = 12'hB82; #1;
    checks++; if (csr_rdata_o !== 32'h1) begin errors++; $display("FAIL minstreth_carry got=%h exp=1", csr_rdata_o); end
    csr_raddr_i = 12'hB02; #1;
    checks++; if (csr_rdata_o !== 32'h0) begin errors++; $display("FAIL minstret_wrap got=%h exp=0", csr_rdata_o); end
  endtask

  task automatic test_reset_mid_commit();
    @(negedge clock);
    issue(1'b1, 5'd7, 32'h77777777, 3'b010, 12'h0, 32'h0, 32'h80000020);
    reset = 1; #1;
    checks++; if ({reg_wen_o, wb_valid_o, redirect_o, wb_ready_o} !== 4'b0000) begin errors++;
      $display("FAIL rst_commit_ctrl got=%b exp=0000", {reg_wen_o, wb_valid_o, redirect_o, wb_ready_o}); end
    @(negedge clock); csr_raddr_i = 12'h341; #1;
    checks++; if (csr_rdata_o !== 32'h0) begin errors++; $display("FAIL rst_mepc got=%h exp=0", csr_rdata_o); end
    csr_raddr_i = 12'h300; #1;
    checks++; if (csr_rdata_o !== 32'h1800) begin errors++; $display("FAIL rst_mstatus got=%h exp=1800", csr_rdata_o); end
    csr_raddr_i = 12'hB02; #1;
    checks++; if (csr_rdata_o !== 32'h0) begin errors++; $display("FAIL rst_minstret got=%h exp=0", csr_rdata_o); end
    reset = 0; #1;
    checks++; if ({wb_ready_o, reg_wen_o, wb_valid_o} !== 3'b100) begin errors++;
      $display("FAIL rst_release got=%b exp=100", {wb_ready_o, reg_wen_o, wb_valid_o}); end
    @(negedge clock); #1;
    checks++; if ({wb_ready_o, wb_valid_o} !== 2'b10) begin errors++;
      $display("FAIL rst_idle_stays got=%b exp=10", {wb_ready_o, wb_valid_o}); end
  endtask

  initial begin
    test_reset();
    test_alu_writeback();
    test_x0_write();
    test_csr_write();
    test_ecall_mret();
    test_back_to_back();
    test_counter_wrap();
    test_reset_mid_commit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
